// File: rtl/bit_string_reverser_if.sv
// bit_string_reverser_if: UART rx/tx handshake plus the parallel word result.
interface bit_string_reverser_if #(
    parameter int WIDTH = 8
);
    logic [7:0]       rx_data;
    logic             new_rx_data;
    logic [7:0]       tx_data;
    logic             new_tx_data;
    logic             tx_busy;
    logic [WIDTH-1:0] value;
    logic             value_valid;
    modport master (
        output rx_data, new_rx_data, tx_busy,
        input  tx_data, new_tx_data, value, value_valid
    );
    modport slave (
        input  rx_data, new_rx_data, tx_busy,
        output tx_data, new_tx_data, value, value_valid
    );
endinterface

// File: rtl/bit_string_reverser.sv
// bit_string_reverser: collects typed ASCII bits from UART rx, publishes the word and prints it back with CR LF.
module bit_string_reverser #(
    parameter int WIDTH   = 8,
    parameter int ECHO    = 1,
    parameter int REVERSE = 1
) (
    input logic clk,
    input logic rst,
    bit_string_reverser_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {S_COLLECT, S_ECHO, S_PRINT, S_CRLF} state_t;
    state_t state, state_n;
    logic [CW-1:0] count, count_n, idx, idx_n;
    logic [WIDTH-1:0] word, word_n, value, value_n, rev, shown;
    logic [7:0] echo_ch, echo_n, ch;
    logic valid, gap, send, ready, full, is_bit, is_bs, done;
    // gap blocks the cycle after every strobe while the transmitter raises busy
    assign ready = !bus.tx_busy && !gap;
    assign full = count == CW'(WIDTH);
    assign is_bit = bus.rx_data[7:1] == 7'h18;
    assign is_bs = bus.rx_data == 8'h08 || bus.rx_data == 8'h7F;
    assign done = full && (state == S_COLLECT || (state == S_ECHO && ready));
    assign shown = value << idx;
    assign bus.new_tx_data = send && ready;
    assign bus.tx_data = send ? ch : 8'h00;
    assign bus.value = value;
    assign bus.value_valid = valid;
    always_comb begin
        rev = '0;
        for (int i = 0; i < WIDTH; i++) rev[i] = word[WIDTH-1-i];
    end
    always_comb begin
        state_n = state;
        count_n = count;
        idx_n = idx;
        word_n = word;
        echo_n = echo_ch;
        value_n = value;
        send = 1'b0;
        ch = 8'h00;
        case (state)
            S_COLLECT:
                if (bus.new_rx_data && is_bit && !full) begin
                    for (int i = 0; i < WIDTH; i++)
                        if (CW'(WIDTH - 1 - i) == count) word_n[i] = bus.rx_data[0];
                    count_n = count + 1'b1;
                    echo_n = bus.rx_data;
                    state_n = ECHO != 0 ? S_ECHO : S_COLLECT;
                end else if (bus.new_rx_data && is_bs && count != '0 && !full) begin
                    count_n = count - 1'b1;
                    echo_n = 8'h08;
                    state_n = ECHO != 0 ? S_ECHO : S_COLLECT;
                end
            S_ECHO: begin
                send = 1'b1;
                ch = echo_ch;
                state_n = ready ? S_COLLECT : S_ECHO;
            end
            S_PRINT: begin
                send = 1'b1;
                ch = {7'h18, shown[WIDTH-1]};
                if (ready) begin
                    idx_n = idx == CW'(WIDTH - 1) ? '0 : idx + 1'b1;
                    state_n = idx == CW'(WIDTH - 1) ? S_CRLF : S_PRINT;
                end
            end
            S_CRLF: begin
                send = 1'b1;
                ch = idx[0] ? 8'h0A : 8'h0D;
                if (ready) begin
                    idx_n = idx[0] ? '0 : CW'(1);
                    state_n = idx[0] ? S_COLLECT : S_CRLF;
                end
            end
            default: state_n = S_COLLECT;
        endcase
        // completion overrides any byte arriving in the same cycle
        if (done) begin
            value_n = REVERSE != 0 ? rev : word;
            count_n = '0;
            idx_n = '0;
            state_n = S_PRINT;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_COLLECT;
            count <= '0;
            idx <= '0;
            word <= '0;
            echo_ch <= '0;
            value <= '0;
            valid <= 1'b0;
            gap <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            idx <= idx_n;
            word <= word_n;
            echo_ch <= echo_n;
            value <= value_n;
            valid <= done;
            gap <= bus.new_tx_data;
        end
    end
endmodule
